cc_rx_unpacker: RTL

Receive-side buffer and width downsizer that sits directly downstream of the clock-domain crossing, in the crossing's output clock domain. It drains SIZE-bit words from the crossing's `out_data`/`out_ready`/`out_strobe` port into a DEPTH-word FIFO. It then emits each word as SIZE/OUT_SIZE slices, least-significant slice first, on a ready/strobe stream of the same polarity. It decouples downstream byte-wide consumers from the crossing's one-word holding register, so the crossing keeps draining while the consumer stalls.

---
 rtl/cc_pkg.sv | 19 +
 rtl/cc_fifo_mem.sv | 25 ++
 rtl/cc_rx_unpacker.sv | 95 +++++++++
 3 files changed

// File: rtl/cc_pkg.sv
// Shared sizing helpers and parameter legality checks for the receive-side
// unpacker and its storage.
package cc_pkg;

  function automatic int ratio(input int size, input int out_size);
    return size / out_size;
  endfunction

  // Bit width able to index n distinct values; never narrower than 1.
  function automatic int width_of(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic bit params_ok(input int size, input int out_size, input int depth);
    return (out_size > 0) && (size % out_size == 0) && (size / out_size >= 1) &&
           (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/cc_fifo_mem.sv
// DEPTH x SIZE word storage: one synchronous write port and an asynchronous
// read of the entry addressed by the read pointer. Contents are never reset.
module cc_fifo_mem
  import cc_pkg::*;
#(
  parameter int SIZE  = 32,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         wr_en,
  input  logic [width_of(DEPTH)-1:0]   wr_ptr,
  input  logic [SIZE-1:0]              wr_data,
  input  logic [width_of(DEPTH)-1:0]   rd_ptr,
  output logic [SIZE-1:0]              rd_data
);

  logic [SIZE-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/cc_rx_unpacker.sv
// Buffers SIZE-bit words drained from the clock-domain crossing and replays
// each one as SIZE/OUT_SIZE slices, least-significant slice first.
module cc_rx_unpacker
  import cc_pkg::*;
#(
  parameter int SIZE     = 32,
  parameter int OUT_SIZE = 8,
  parameter int DEPTH    = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic [SIZE-1:0]              src_data,
  input  logic                         src_ready,
  output logic                         src_strobe,
  output logic [OUT_SIZE-1:0]          dst_data,
  output logic                         dst_ready,
  output logic                         dst_last,
  input  logic                         dst_strobe,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int RATIO   = ratio(SIZE, OUT_SIZE);
  localparam int PTR_W   = width_of(DEPTH);
  localparam int IDX_W   = width_of(RATIO);
  localparam int LEVEL_W = $clog2(DEPTH + 1);
  localparam logic [LEVEL_W-1:0] LEVEL_FULL = LEVEL_W'(DEPTH);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(RATIO - 1);

  if (!params_ok(SIZE, OUT_SIZE, DEPTH)) begin : g_bad_params
    $error("cc_rx_unpacker: SIZE must be a multiple of OUT_SIZE and DEPTH a power of two >= 2");
  end

  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [IDX_W-1:0]    idx;
  logic [SIZE-1:0]     head_word;
  logic                full;
  logic                push;
  logic                pop;
  logic                free;
  logic [OUT_SIZE-1:0] slices [RATIO];

  cc_fifo_mem #(
    .SIZE  (SIZE),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_ptr  (wr_ptr),
    .wr_data (src_data),
    .rd_ptr  (rd_ptr),
    .rd_data (head_word)
  );

  // A full FIFO refuses the word even while its head is being freed; the
  // freed slot opens on the following cycle, keeping src_strobe off dst_strobe.
  assign full       = (level == LEVEL_FULL);
  assign src_strobe = src_ready & ~full & ~flush & ~rst;
  assign push       = src_strobe;

  assign dst_ready  = (level != '0);
  assign dst_last   = dst_ready & (idx == IDX_LAST);
  assign pop        = dst_ready & dst_strobe & ~flush;
  assign free       = pop & (idx == IDX_LAST);

  for (genvar i = 0; i < RATIO; i++) begin : g_slice
    assign slices[i] = head_word[i*OUT_SIZE +: OUT_SIZE];
  end
  assign dst_data = slices[idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      idx    <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      idx    <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  idx    <= free ? '0 : idx + 1'b1;
      if (free) rd_ptr <= rd_ptr + 1'b1;
      case ({push, free})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule
